// File: rtl/msb_pos_pkg.sv
// Shared types and helpers for the pipelined bit-position encoder.
package msb_pos_pkg;

    typedef enum logic {
        MODE_MSB = 1'b0,
        MODE_LSB = 1'b1
    } pos_mode_t;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned pos_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/group_pos_enc.sv
// Combinational per-group encoder: any-set flag plus MSB or LSB index of one group.
module group_pos_enc
    import msb_pos_pkg::*;
#(
    parameter int unsigned GROUP_W = 8
) (
    input  logic [GROUP_W-1:0]         grp,
    input  pos_mode_t                  mode,
    output logic                       any,
    output logic [$clog2(GROUP_W)-1:0] idx
);

    localparam int unsigned IDX_W = $clog2(GROUP_W);

    // Last hit in scan order wins, so scan upward for MSB and downward for LSB.
    always_comb begin
        any = |grp;
        idx = '0;
        if (mode == MODE_MSB) begin
            for (int i = 0; i < int'(GROUP_W); i++) begin
                if (grp[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = int'(GROUP_W) - 1; i >= 0; i--) begin
                if (grp[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/msb_pos_pipe.sv
// Two-stage streaming MSB/LSB position encoder with valid/ready on both sides.
module msb_pos_pipe
    import msb_pos_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned GROUP_W   = 8,
    parameter int unsigned TAG_W     = 4,
    localparam int unsigned OUT_WIDTH = $clog2(IN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_pos,
    output logic                 out_zero,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned NGROUPS = IN_WIDTH / GROUP_W;
    localparam int unsigned GSEL_W  = pos_width(NGROUPS);
    localparam int unsigned LIDX_W  = $clog2(GROUP_W);
    localparam int unsigned FULL_W  = GSEL_W + LIDX_W;

    logic                 s2_load, s1_load, in_fire;

    logic [NGROUPS-1:0]   grp_any;
    logic [LIDX_W-1:0]    grp_idx [NGROUPS];

    logic                 s1_v;
    logic [NGROUPS-1:0]   s1_any;
    logic [LIDX_W-1:0]    s1_idx [NGROUPS];
    pos_mode_t            s1_mode;
    logic [TAG_W-1:0]     s1_tag;

    logic [GSEL_W-1:0]    gsel;
    logic [LIDX_W-1:0]    lidx;
    logic [FULL_W-1:0]    pos_full;

    logic                 s2_v;
    logic [OUT_WIDTH-1:0] s2_pos;
    logic                 s2_zero;
    logic [TAG_W-1:0]     s2_tag;

    // No skid buffer: ready ripples back combinationally from out_ready.
    assign s2_load  = !s2_v || out_ready;
    assign s1_load  = !s1_v || s2_load;
    assign in_ready = s1_load && !rst;
    assign in_fire  = in_valid && in_ready;

    for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
        group_pos_enc #(
            .GROUP_W (GROUP_W)
        ) u_enc (
            .grp  (in_data[g*GROUP_W +: GROUP_W]),
            .mode (pos_mode_t'(in_mode)),
            .any  (grp_any[g]),
            .idx  (grp_idx[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_any  <= '0;
            s1_mode <= MODE_MSB;
            s1_tag  <= '0;
            for (int g = 0; g < int'(NGROUPS); g++) s1_idx[g] <= '0;
        end else if (s1_load) begin
            s1_v <= in_fire;
            if (in_fire) begin
                s1_any  <= grp_any;
                s1_mode <= pos_mode_t'(in_mode);
                s1_tag  <= in_tag;
                for (int g = 0; g < int'(NGROUPS); g++) s1_idx[g] <= grp_idx[g];
            end
        end
    end

    // Group select; an all-zero word leaves gsel and lidx at zero.
    always_comb begin
        gsel = '0;
        lidx = '0;
        if (s1_mode == MODE_MSB) begin
            for (int g = 0; g < int'(NGROUPS); g++) begin
                if (s1_any[g]) begin
                    gsel = GSEL_W'(g);
                    lidx = s1_idx[g];
                end
            end
        end else begin
            for (int g = int'(NGROUPS) - 1; g >= 0; g--) begin
                if (s1_any[g]) begin
                    gsel = GSEL_W'(g);
                    lidx = s1_idx[g];
                end
            end
        end
        pos_full = {gsel, lidx};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_pos  <= '0;
            s2_zero <= 1'b0;
            s2_tag  <= '0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                // With a single group the 1-bit gsel is always zero and drops off here.
                s2_pos  <= pos_full[OUT_WIDTH-1:0];
                s2_zero <= ~|s1_any;
                s2_tag  <= s1_tag;
            end
        end
    end

    assign out_valid = s2_v;
    assign out_pos   = s2_pos;
    assign out_zero  = s2_zero;
    assign out_tag   = s2_tag;

endmodule
